// File: rtl/peri_bus_bridge.sv
// rtl/peri_bus_bridge.sv - CPU to peripheral bridge with clock enables, slot decode, wait states and ready timeout
// Decodes each CPU request into one of NSLOT base/mask windows and runs a registered cs/strobe cycle.
module peri_bus_bridge #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8,
  parameter int NSLOT      = 4,
  parameter int CLKEN_BITS = 2,
  parameter logic [NSLOT*ADDR_W-1:0] SLOT_BASE = {13'h0000, 13'h1000, 13'h0810, 13'h0800},
  parameter logic [NSLOT*ADDR_W-1:0] SLOT_MASK = {13'h1800, 13'h1000, 13'h1FF0, 13'h1FF0},
  parameter logic [NSLOT*4-1:0]      SLOT_WAIT = {4'd0, 4'd2, 4'd1, 4'd0},
  parameter int TIMEOUT    = 15
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic                    ext_bus,
  input  logic                    req,
  input  logic                    rwb,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata,
  output logic                    ready,
  output logic                    err,
  output logic                    cpu_clken,
  output logic                    per_clken,
  output logic                    phi2,
  output logic [NSLOT-1:0]        slot_cs,
  output logic                    slot_we,
  output logic [ADDR_W-1:0]       slot_addr,
  output logic [DATA_W-1:0]       slot_wdata,
  input  logic [NSLOT*DATA_W-1:0] slot_rdata,
  input  logic [NSLOT-1:0]        slot_rdy
);

  localparam int SEL_W = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [7:0] TMO = 8'(TIMEOUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACCESS  = 2'd1;
  localparam logic [1:0] WAITRDY = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state;
  logic [CLKEN_BITS-1:0] cnt;
  logic                  armed;
  logic                  rwb_q;
  logic [SEL_W-1:0]      sel_q;
  logic [3:0]            wait_cnt;
  logic [7:0]            tmo_cnt;
  logic [7:0]            tmo_next;
  logic                  chk_phase;
  logic                  hit;
  logic [SEL_W-1:0]      hit_idx;

  // Scan from the top so the lowest matching slot overwrites any higher one.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (((addr ^ SLOT_BASE[i*ADDR_W +: ADDR_W]) & SLOT_MASK[i*ADDR_W +: ADDR_W]) == '0) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign tmo_next  = tmo_cnt + 8'd1;
  assign chk_phase = ((state == ACCESS) && (wait_cnt == 4'd0)) || (state == WAITRDY);

  always_ff @(posedge clk) begin
    if (res) begin
      cnt        <= '0;
      cpu_clken  <= 1'b0;
      per_clken  <= 1'b0;
      phi2       <= 1'b0;
      state      <= IDLE;
      armed      <= 1'b1;
      rwb_q      <= 1'b0;
      sel_q      <= '0;
      wait_cnt   <= 4'd0;
      tmo_cnt    <= 8'd0;
      rdata      <= '1;
      ready      <= 1'b0;
      err        <= 1'b0;
      slot_cs    <= '0;
      slot_we    <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else begin
      cnt       <= cnt + 1'b1;
      cpu_clken <= &cnt;
      per_clken <= cpu_clken;
      phi2      <= cnt[CLKEN_BITS-1];
      ready     <= 1'b0;
      err       <= 1'b0;
      // A request is only re-accepted after req has been seen low once.
      if (!req) armed <= 1'b1;

      case (state)
        IDLE: begin
          if (req && !ext_bus && armed) begin
            armed      <= 1'b0;
            slot_addr  <= addr;
            slot_wdata <= wdata;
            rwb_q      <= rwb;
            if (hit) begin
              slot_cs  <= NSLOT'(1) << hit_idx;
              slot_we  <= !rwb;
              sel_q    <= hit_idx;
              wait_cnt <= SLOT_WAIT[int'(hit_idx)*4 +: 4];
              tmo_cnt  <= 8'd0;
              state    <= ACCESS;
            end else begin
              state <= DONE;
              ready <= 1'b1;
              err   <= 1'b1;
              if (rwb) rdata <= '1;
            end
          end
        end
        ACCESS: begin
          if (per_clken && (wait_cnt != 4'd0)) wait_cnt <= wait_cnt - 1'b1;
        end
        WAITRDY: ;
        default: state <= IDLE;
      endcase

      // Wait states exhausted: sample the slot ready on every peripheral enable.
      if (per_clken && chk_phase) begin
        if (slot_rdy[sel_q] || (tmo_next >= TMO)) begin
          state   <= DONE;
          ready   <= 1'b1;
          err     <= !slot_rdy[sel_q];
          slot_cs <= '0;
          slot_we <= 1'b0;
          if (rwb_q) rdata <= slot_rdy[sel_q] ? slot_rdata[int'(sel_q)*DATA_W +: DATA_W] : '1;
        end else begin
          tmo_cnt <= tmo_next;
          state   <= WAITRDY;
        end
      end
    end
  end

endmodule

// File: tb/tb_peri_bus_bridge.sv
// tb/tb_peri_bus_bridge.sv - self-checking bench for peri_bus_bridge
// Per-cycle comparison against a transaction-level model plus directed literal checks.
module tb_peri_bus_bridge;

  localparam int BASE_T[4] = '{13'h0800, 13'h0810, 13'h1000, 13'h0000};
  localparam int MASK_T[4] = '{13'h1FF0, 13'h1FF0, 13'h1000, 13'h1800};
  localparam int WAIT_T[4] = '{0, 1, 2, 0};
  localparam int TMO_M     = 15;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        ext_bus = 1'b0;
  logic        req = 1'b0;
  logic        rwb = 1'b1;
  logic [12:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ready, err, cpu_clken, per_clken, phi2, slot_we;
  logic [3:0]  slot_cs;
  logic [12:0] slot_addr;
  logic [7:0]  slot_wdata;
  logic [31:0] slot_rdata = {8'h3C, 8'hA5, 8'h77, 8'h5A};
  logic [3:0]  slot_rdy = 4'hF;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic        acc_valid = 1'b0;
  int          acc_n0, acc_n1;
  logic [3:0]  acc_cs;
  logic        acc_we, acc_rd, acc_err;
  logic [12:0] acc_addr;
  logic [7:0]  acc_wdata, acc_rdata;
  logic [7:0]  held = 8'hFF;

  peri_bus_bridge dut (
    .clk(clk), .res(res), .ext_bus(ext_bus), .req(req), .rwb(rwb),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .cpu_clken(cpu_clken), .per_clken(per_clken), .phi2(phi2),
    .slot_cs(slot_cs), .slot_we(slot_we), .slot_addr(slot_addr),
    .slot_wdata(slot_wdata), .slot_rdata(slot_rdata), .slot_rdy(slot_rdy)
  );

  always #5 clk = ~clk;

  // n = clock edges since reset was released
  always @(posedge clk) n <= res ? 0 : n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%h required=%h", nm, n, act, exp);
    end
  endtask

  function automatic bit exp_cpu(input int m);  return (m >= 4) && (m % 4 == 0); endfunction
  function automatic bit exp_per(input int m);  return (m >= 5) && (m % 4 == 1); endfunction
  function automatic bit exp_phi2(input int m); return (m >= 3) && ((m % 4 == 3) || (m % 4 == 0)); endfunction

  function automatic int decode(input int a);
    for (int i = 0; i < 4; i++)
      if (((a ^ BASE_T[i]) & MASK_T[i]) == 0) return i;
    return -1;
  endfunction

  // Predicts a whole access from the cycle it is accepted in.
  task automatic model_set(input logic [12:0] a, input logic rw, input logic [7:0] wd, input logic [3:0] rdy);
    int idx, k, e;
    idx = decode(int'(a));
    acc_n0 = n + 1;
    if (idx < 0) begin
      acc_n1 = acc_n0; acc_cs = 4'b0; acc_err = 1'b1; acc_rdata = 8'hFF;
    end else begin
      k = WAIT_T[idx] + (rdy[idx] ? 1 : TMO_M);
      e = acc_n0;
      while (k > 0) begin
        e++;
        if (exp_per(e - 1)) k--;
      end
      acc_n1 = e;
      acc_cs = 4'b0001 << idx;
      acc_err = !rdy[idx];
      acc_rdata = rdy[idx] ? slot_rdata[idx*8 +: 8] : 8'hFF;
    end
    acc_we = !rw; acc_rd = rw; acc_addr = a; acc_wdata = wd;
    acc_valid = 1'b1;
  endtask

  always @(negedge clk) begin
    bit act;
    if (n == 0) held = 8'hFF;
    else if (acc_valid && n == acc_n1 && acc_rd) held = acc_rdata;
    act = acc_valid && (n >= acc_n0) && (n < acc_n1);
    chk("cpu_clken", cpu_clken, exp_cpu(n));
    chk("per_clken", per_clken, exp_per(n));
    chk("phi2", phi2, exp_phi2(n));
    chk("slot_cs", slot_cs, act ? acc_cs : 4'b0);
    chk("slot_we", slot_we, act ? acc_we : 1'b0);
    if (act) chk("slot_addr", slot_addr, acc_addr);
    if (act && acc_we) chk("slot_wdata", slot_wdata, acc_wdata);
    chk("ready", ready, acc_valid && n == acc_n1);
    chk("err", err, acc_valid && n == acc_n1 && acc_err);
    chk("rdata", rdata, held);
  end

  task automatic do_access(input logic [12:0] a, input logic rw, input logic [7:0] wd, input logic [3:0] rdy,
                           input int hold, output int rdy_n, output logic got_err, output logic [3:0] cs_seen,
                           output int cs_cycles);
    @(posedge clk); #1;
    addr = a; rwb = rw; wdata = wd; slot_rdy = rdy; req = 1'b1;
    model_set(a, rw, wd, rdy);
    rdy_n = -1; got_err = 1'b0; cs_seen = 4'b0; cs_cycles = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (c == 1) begin addr = ~a; wdata = ~wd; end
      if (slot_cs != 4'b0) begin cs_cycles++; cs_seen |= slot_cs; end
      if (ready) begin rdy_n = n; got_err = err; break; end
    end
    if (rdy_n < 0) chk("ready_timeout", 0, 1);
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] cpu_h, per_h, phi_h;
    int rn, cc, cnt_cs, cnt_rdy;
    logic e;
    logic [3:0] cs;

    repeat (2) @(posedge clk);
    #1 res = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); @(negedge clk);
      cpu_h[i] = cpu_clken; per_h[i] = per_clken; phi_h[i] = phi2;
    end
    chk("cpu_clken_pattern", cpu_h, 16'h8888);
    chk("per_clken_pattern", per_h, 16'h1110);
    chk("phi2_pattern", phi_h, 16'hCCCC);

    do_access(13'h0805, 1'b1, 8'h00, 4'hF, 0, rn, e, cs, cc);
    chk("rd0_ready_cycle", rn, 22);
    chk("rd0_cs", cs, 4'b0001);
    chk("rd0_cs_cycles", cc, 4);
    chk("rd0_err", e, 1'b0);
    chk("rd0_rdata", rdata, 8'h5A);
    chk("rd0_slot_addr", slot_addr, 13'h0805);

    do_access(13'h1234, 1'b0, 8'hC3, 4'hF, 0, rn, e, cs, cc);
    chk("wr2_cs", cs, 4'b0100);
    chk("wr2_cs_cycles", cc, 12);
    chk("wr2_rdata_kept", rdata, 8'h5A);

    do_access(13'h0003, 1'b1, 8'h00, 4'hF, 3, rn, e, cs, cc);
    chk("rd3_cs", cs, 4'b1000);
    chk("rd3_rdata", rdata, 8'h3C);

    do_access(13'h0900, 1'b0, 8'h11, 4'hF, 0, rn, e, cs, cc);
    chk("wmiss_err", e, 1'b1);
    chk("wmiss_cs", cs, 4'b0000);
    chk("wmiss_rdata_kept", rdata, 8'h3C);

    do_access(13'h0900, 1'b1, 8'h00, 4'hF, 0, rn, e, cs, cc);
    chk("rmiss_err", e, 1'b1);
    chk("rmiss_rdata", rdata, 8'hFF);

    do_access(13'h0815, 1'b1, 8'h00, 4'b1101, 0, rn, e, cs, cc);
    chk("tmo_cs", cs, 4'b0010);
    chk("tmo_err", e, 1'b1);
    chk("tmo_rdata", rdata, 8'hFF);

    do_access(13'h0815, 1'b1, 8'h00, 4'hF, 0, rn, e, cs, cc);
    chk("rd1_err", e, 1'b0);
    chk("rd1_rdata", rdata, 8'h77);

    @(posedge clk); #1;
    acc_valid = 1'b0; ext_bus = 1'b1; req = 1'b1; rwb = 1'b1; addr = 13'h0805;
    cnt_cs = 0; cnt_rdy = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (slot_cs != 4'b0) cnt_cs++;
      if (ready) cnt_rdy++;
    end
    chk("ext_cs_count", cnt_cs, 0);
    chk("ext_ready_count", cnt_rdy, 0);
    @(posedge clk); #1;
    req = 1'b0; ext_bus = 1'b0;
    @(posedge clk); #1;

    addr = 13'h1000; rwb = 1'b1; slot_rdy = 4'hF; req = 1'b1;
    model_set(13'h1000, 1'b1, wdata, 4'hF);
    cs = 4'b0;
    for (int c = 0; c < 10 && cs == 4'b0; c++) begin
      @(negedge clk);
      cs = slot_cs;
    end
    chk("rst_cs_before", cs, 4'b0100);
    @(posedge clk); #1;
    res = 1'b1; req = 1'b0;
    @(posedge clk); #1;
    acc_valid = 1'b0; res = 1'b0;
    @(negedge clk);
    chk("rst_cs_after", slot_cs, 4'b0);
    chk("rst_ready_after", ready, 1'b0);
    chk("rst_rdata", rdata, 8'hFF);

    do_access(13'h1000, 1'b1, 8'h00, 4'hF, 0, rn, e, cs, cc);
    chk("post_rst_cs", cs, 4'b0100);
    chk("post_rst_err", e, 1'b0);
    chk("post_rst_rdata", rdata, 8'hA5);

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
